// File: rtl/combi_isa_modectl_if.sv
// Handshake bundle between the combi decode stage / hazard unit and the ISA-mode controller.
//  master : decode stage + hazard unit (drives decode flags, force request, flush acknowledge)
//  slave  : combi_isa_modectl (drives current mode, flush/stall requests, illegal flag, switch count)
//  validD      per-ISA decode-legal flags       instrValidD  real instruction in decode slot
//  stallD      decode stalled                   forceValid   explicit mode change
//  forceIsa    target mode of forceValid        flushAck     F/D flushed, one-cycle pulse
//  isaD        current mode                     flushReq     request F/D flush
//  stallReq    hold fetch/decode                illegalD     no ISA decodes this instruction
//  switchCnt   committed-switch count (saturating)
interface combi_isa_modectl_if #(
  parameter int NUM_ISA = 2,
  parameter int ISA_W   = 1
);
  logic [NUM_ISA-1:0] validD;
  logic               instrValidD;
  logic               stallD;
  logic               forceValid;
  logic [ISA_W-1:0]   forceIsa;
  logic               flushAck;
  logic [ISA_W-1:0]   isaD;
  logic               flushReq;
  logic               stallReq;
  logic               illegalD;
  logic [7:0]         switchCnt;

  modport master (
    output validD, instrValidD, stallD, forceValid, forceIsa, flushAck,
    input  isaD, flushReq, stallReq, illegalD, switchCnt
  );

  modport slave (
    input  validD, instrValidD, stallD, forceValid, forceIsa, flushAck,
    output isaD, flushReq, stallReq, illegalD, switchCnt
  );
endinterface

// File: rtl/combi_isa_modectl.sv
// Registered ISA-mode controller for the combi decode stage.
// A foreign ISA must be the lowest legal decode for SWITCH_THR consecutive qualified cycles
// (or be requested through forceValid) before a switch starts. A switch raises flushReq and
// stallReq, waits for flushAck from the hazard unit, commits the new mode, then spends one
// SETTLE cycle with stallReq still high before normal decoding resumes.
// Ports:
//  clk      clock
//  reset_n  asynchronous active-low reset
//  bus      combi_isa_modectl_if slave modport (decode flags in, mode/flush/stall/illegal out)
module combi_isa_modectl #(
  parameter int NUM_ISA    = 2,
  parameter int ISA_W      = 1,
  parameter int RESET_ISA  = 0,
  parameter int CONF_W     = 2,
  parameter int SWITCH_THR = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  combi_isa_modectl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [ISA_W-1:0]  RESET_V   = ISA_W'(RESET_ISA);
  localparam logic [ISA_W:0]    NUM_ISA_V = (ISA_W + 1)'(NUM_ISA);
  localparam logic [CONF_W-1:0] THR_V     = CONF_W'(SWITCH_THR);
  localparam logic [CONF_W-1:0] CONF_ONE  = CONF_W'(1);
  localparam logic [CONF_W-1:0] CONF_MAX  = {CONF_W{1'b1}};

  state_t             state_r, state_s;
  logic [ISA_W-1:0]   isa_r, isa_s;
  logic [ISA_W-1:0]   tgt_r, tgt_s;
  logic [ISA_W-1:0]   cand_r, cand_s;
  logic [CONF_W-1:0]  conf_r, conf_s;
  logic               illegal_r, illegal_s;
  logic               flush_r, flush_s;
  logic               stall_r, stall_s;
  logic [7:0]         cnt_r, cnt_s;

  logic [ISA_W-1:0]   pick_s;
  logic [CONF_W-1:0]  conf_new_s;
  logic               cur_valid_s;
  logic               force_ok_s;
  logic               q_s;

  // Lowest-index ISA whose valid flag is set (0 when none are set).
  function automatic logic [ISA_W-1:0] lowest_valid(input logic [NUM_ISA-1:0] v);
    logic found;
    lowest_valid = {ISA_W{1'b0}};
    found        = 1'b0;
    for (int i = 0; i < NUM_ISA; i++) begin
      if (v[i] && !found) begin
        lowest_valid = ISA_W'(i);
        found        = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_s   = state_r;
    isa_s     = isa_r;
    tgt_s     = tgt_r;
    cand_s    = cand_r;
    conf_s    = conf_r;
    illegal_s = 1'b0;
    cnt_s     = cnt_r;

    pick_s      = lowest_valid(bus.validD);
    // isa_r never exceeds NUM_ISA-1, so the index stays inside validD.
    cur_valid_s = ({1'b0, isa_r} < NUM_ISA_V) ? bus.validD[isa_r] : 1'b0;
    force_ok_s  = ({1'b0, bus.forceIsa} < NUM_ISA_V);
    q_s         = bus.instrValidD & ~bus.stallD & (state_r == RUN);

    // Same candidate keeps counting (saturating); a new candidate restarts at one.
    if (pick_s == cand_r) begin
      conf_new_s = (conf_r == CONF_MAX) ? conf_r : conf_r + CONF_ONE;
    end else begin
      conf_new_s = CONF_ONE;
    end

    case (state_r)
      RUN: begin
        // Force is evaluated before q so it also wins over stall and a q-switch.
        if (bus.forceValid) begin
          if (!force_ok_s) begin
            illegal_s = 1'b1;
          end else if (bus.forceIsa != isa_r) begin
            tgt_s   = bus.forceIsa;
            state_s = FLUSH;
          end else begin
            state_s = RUN;
          end
        end else if (q_s) begin
          if (cur_valid_s) begin
            conf_s = {CONF_W{1'b0}};
          end else if (|bus.validD) begin
            cand_s = pick_s;
            conf_s = conf_new_s;
            if (conf_new_s >= THR_V) begin
              tgt_s   = pick_s;
              state_s = FLUSH;
            end else begin
              state_s = RUN;
            end
          end else begin
            illegal_s = 1'b1;
            conf_s    = {CONF_W{1'b0}};
          end
        end else begin
          state_s = RUN;
        end
      end
      FLUSH: begin
        // A force during FLUSH retargets the switch; it also applies to a same-cycle ack.
        if (bus.forceValid && force_ok_s) begin
          tgt_s = bus.forceIsa;
        end else begin
          tgt_s = tgt_r;
        end
        if (bus.flushAck) begin
          isa_s   = tgt_s;
          conf_s  = {CONF_W{1'b0}};
          cnt_s   = (cnt_r == 8'd255) ? cnt_r : cnt_r + 8'd1;
          state_s = SETTLE;
        end else begin
          state_s = FLUSH;
        end
      end
      SETTLE: begin
        state_s = RUN;
      end
      default: begin
        state_s = RUN;
      end
    endcase

    // Handshake outputs follow the state being entered so they are registered yet on time.
    flush_s = (state_s == FLUSH);
    stall_s = (state_s != RUN);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= RUN;
      isa_r     <= RESET_V;
      tgt_r     <= RESET_V;
      cand_r    <= {ISA_W{1'b0}};
      conf_r    <= {CONF_W{1'b0}};
      illegal_r <= 1'b0;
      flush_r   <= 1'b0;
      stall_r   <= 1'b0;
      cnt_r     <= 8'd0;
    end else begin
      state_r   <= state_s;
      isa_r     <= isa_s;
      tgt_r     <= tgt_s;
      cand_r    <= cand_s;
      conf_r    <= conf_s;
      illegal_r <= illegal_s;
      flush_r   <= flush_s;
      stall_r   <= stall_s;
      cnt_r     <= cnt_s;
    end
  end

  assign bus.isaD      = isa_r;
  assign bus.flushReq  = flush_r;
  assign bus.stallReq  = stall_r;
  assign bus.illegalD  = illegal_r;
  assign bus.switchCnt = cnt_r;

endmodule

// File: tb/tb_combi_isa_modectl.sv
// Self-checking bench for combi_isa_modectl: directed scenarios with fixed expectations plus
// a randomized run compared against a behavioural model of the mode-switch rules.
module tb_combi_isa_modectl;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  combi_isa_modectl_if #(.NUM_ISA(2), .ISA_W(1)) bus2 ();
  combi_isa_modectl_if #(.NUM_ISA(3), .ISA_W(2)) bus3 ();

  combi_isa_modectl #(.NUM_ISA(2), .ISA_W(1), .RESET_ISA(0), .CONF_W(2), .SWITCH_THR(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2)
  );

  combi_isa_modectl #(.NUM_ISA(3), .ISA_W(2), .RESET_ISA(0), .CONF_W(2), .SWITCH_THR(2)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the 2-ISA instance.
  int   m_isa, m_cand, m_streak, m_target, m_switches;
  bit   m_switching, m_settle, m_illegal;

  task automatic model_reset();
    m_isa = 0; m_cand = 0; m_streak = 0; m_target = 0; m_switches = 0;
    m_switching = 0; m_settle = 0; m_illegal = 0;
  endtask

  task automatic model_step();
    int c;
    m_illegal = 0;
    if (m_switching) begin
      if (bus2.forceValid) m_target = int'(bus2.forceIsa);
      if (bus2.flushAck) begin
        m_isa = m_target; m_streak = 0; m_switching = 0; m_settle = 1;
        if (m_switches < 255) m_switches++;
      end
    end else if (m_settle) begin
      m_settle = 0;
    end else if (bus2.forceValid) begin
      if (int'(bus2.forceIsa) != m_isa) begin
        m_target = int'(bus2.forceIsa); m_switching = 1;
      end
    end else if (bus2.instrValidD && !bus2.stallD) begin
      if (bus2.validD[m_isa]) begin
        m_streak = 0;
      end else if (bus2.validD == 2'b00) begin
        m_illegal = 1; m_streak = 0;
      end else begin
        c = bus2.validD[0] ? 0 : 1;
        m_streak = (c == m_cand) ? ((m_streak < 3) ? m_streak + 1 : 3) : 1;
        m_cand = c;
        if (m_streak >= 2) begin
          m_target = c; m_switching = 1;
        end
      end
    end
  endtask

  task automatic idle_inputs();
    bus2.validD = 2'b00; bus2.instrValidD = 1'b0; bus2.stallD = 1'b0;
    bus2.forceValid = 1'b0; bus2.forceIsa = 1'b0; bus2.flushAck = 1'b0;
    bus3.validD = 3'b000; bus3.instrValidD = 1'b0; bus3.stallD = 1'b0;
    bus3.forceValid = 1'b0; bus3.forceIsa = 2'd0; bus3.flushAck = 1'b0;
  endtask

  // One clock: the model consumes the same inputs the DUT saw; returns 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (bus2.isaD !== 1'b0) $display("FAIL reset_isa got %0d exp 0", bus2.isaD); else n_pass++;
    n_checks++; if (bus2.flushReq !== 1'b0) $display("FAIL reset_flush got %0b exp 0", bus2.flushReq); else n_pass++;
    n_checks++; if (bus2.stallReq !== 1'b0) $display("FAIL reset_stall got %0b exp 0", bus2.stallReq); else n_pass++;
    n_checks++; if (bus2.illegalD !== 1'b0) $display("FAIL reset_illegal got %0b exp 0", bus2.illegalD); else n_pass++;
    n_checks++; if (bus2.switchCnt !== 8'd0) $display("FAIL reset_cnt got %0d exp 0", bus2.switchCnt); else n_pass++;
  endtask

  task automatic test_hysteresis();
    apply_reset();
    bus2.validD = 2'b10; bus2.instrValidD = 1'b1;
    cyc();
    n_checks++; if (bus2.flushReq !== 1'b0) $display("FAIL hyst_first_q got %0b exp 0", bus2.flushReq); else n_pass++;
    cyc();
    n_checks++; if (bus2.flushReq !== 1'b1) $display("FAIL hyst_flush_start got %0b exp 1", bus2.flushReq); else n_pass++;
    n_checks++; if (bus2.stallReq !== 1'b1) $display("FAIL hyst_stall_start got %0b exp 1", bus2.stallReq); else n_pass++;
    bus2.validD = 2'b00; bus2.instrValidD = 1'b0;
    cyc(); cyc();
    n_checks++; if (bus2.flushReq !== 1'b1 || bus2.isaD !== 1'b0)
      $display("FAIL hyst_wait_ack got flush=%0b isa=%0d exp flush=1 isa=0", bus2.flushReq, bus2.isaD); else n_pass++;
    bus2.flushAck = 1'b1;
    cyc();
    bus2.flushAck = 1'b0;
    n_checks++; if (bus2.isaD !== 1'b1) $display("FAIL hyst_isa got %0d exp 1", bus2.isaD); else n_pass++;
    n_checks++; if (bus2.flushReq !== 1'b0 || bus2.stallReq !== 1'b1)
      $display("FAIL hyst_settle got flush=%0b stall=%0b exp flush=0 stall=1", bus2.flushReq, bus2.stallReq); else n_pass++;
    n_checks++; if (bus2.switchCnt !== 8'd1) $display("FAIL hyst_cnt got %0d exp 1", bus2.switchCnt); else n_pass++;
    cyc();
    n_checks++; if (bus2.stallReq !== 1'b0) $display("FAIL hyst_resume got %0b exp 0", bus2.stallReq); else n_pass++;
  endtask

  task automatic test_glitch();
    logic [1:0] seq [3];
    apply_reset();
    seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b10;
    bus2.instrValidD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus2.validD = seq[i];
      cyc();
      n_checks++; if (bus2.flushReq !== 1'b0) $display("FAIL glitch_step%0d got %0b exp 0", i, bus2.flushReq); else n_pass++;
    end
    bus2.instrValidD = 1'b0;
    cyc();
    n_checks++; if (bus2.flushReq !== 1'b0 || bus2.isaD !== 1'b0)
      $display("FAIL glitch_final got flush=%0b isa=%0d exp flush=0 isa=0", bus2.flushReq, bus2.isaD); else n_pass++;
  endtask

  task automatic test_illegal_stall();
    apply_reset();
    bus2.validD = 2'b00; bus2.instrValidD = 1'b1;
    cyc();
    n_checks++; if (bus2.illegalD !== 1'b1) $display("FAIL illegal_pulse got %0b exp 1", bus2.illegalD); else n_pass++;
    bus2.instrValidD = 1'b0;
    cyc();
    n_checks++; if (bus2.illegalD !== 1'b0 || bus2.isaD !== 1'b0)
      $display("FAIL illegal_end got ill=%0b isa=%0d exp ill=0 isa=0", bus2.illegalD, bus2.isaD); else n_pass++;
    bus2.validD = 2'b10; bus2.instrValidD = 1'b1; bus2.stallD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_checks++; if (bus2.flushReq !== 1'b0) $display("FAIL stall_hold%0d got %0b exp 0", i, bus2.flushReq); else n_pass++;
    end
    // conf must still be 0: one unstalled q-cycle may only bring it to 1.
    bus2.stallD = 1'b0;
    cyc();
    n_checks++; if (bus2.flushReq !== 1'b0) $display("FAIL stall_conf got %0b exp 0", bus2.flushReq); else n_pass++;
  endtask

  task automatic test_force();
    apply_reset();
    bus2.stallD = 1'b1; bus2.forceValid = 1'b1; bus2.forceIsa = 1'b1;
    cyc();
    bus2.forceValid = 1'b0; bus2.stallD = 1'b0;
    n_checks++; if (bus2.flushReq !== 1'b1) $display("FAIL force_flush got %0b exp 1", bus2.flushReq); else n_pass++;
    bus2.flushAck = 1'b1;
    cyc();
    bus2.flushAck = 1'b0;
    n_checks++; if (bus2.isaD !== 1'b1) $display("FAIL force_isa got %0d exp 1", bus2.isaD); else n_pass++;
    cyc();
    bus2.forceValid = 1'b1; bus2.forceIsa = 1'b1;
    cyc();
    bus2.forceValid = 1'b0;
    n_checks++; if (bus2.flushReq !== 1'b0 || bus2.stallReq !== 1'b0)
      $display("FAIL force_same got flush=%0b stall=%0b exp 0 0", bus2.flushReq, bus2.stallReq); else n_pass++;
  endtask

  task automatic test_reset_mid_switch();
    apply_reset();
    bus2.forceValid = 1'b1; bus2.forceIsa = 1'b1;
    cyc();
    bus2.forceValid = 1'b0;
    bus2.flushAck = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus2.flushReq !== 1'b0 || bus2.stallReq !== 1'b0 || bus2.isaD !== 1'b0)
      $display("FAIL midreset got flush=%0b stall=%0b isa=%0d exp 0 0 0", bus2.flushReq, bus2.stallReq, bus2.isaD); else n_pass++;
    @(posedge clk);
    #1;
    bus2.flushAck = 1'b0;
    n_checks++; if (bus2.isaD !== 1'b0 || bus2.switchCnt !== 8'd0)
      $display("FAIL midreset_hold got isa=%0d cnt=%0d exp 0 0", bus2.isaD, bus2.switchCnt); else n_pass++;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_three_isa();
    apply_reset();
    bus3.validD = 3'b110; bus3.instrValidD = 1'b1;
    cyc(); cyc();
    bus3.instrValidD = 1'b0; bus3.validD = 3'b000;
    n_checks++; if (bus3.flushReq !== 1'b1) $display("FAIL isa3_flush got %0b exp 1", bus3.flushReq); else n_pass++;
    bus3.flushAck = 1'b1;
    cyc();
    bus3.flushAck = 1'b0;
    n_checks++; if (bus3.isaD !== 2'd1) $display("FAIL isa3_lowest got %0d exp 1", bus3.isaD); else n_pass++;
    cyc();
    bus3.forceValid = 1'b1; bus3.forceIsa = 2'd3;
    cyc();
    bus3.forceValid = 1'b0;
    n_checks++; if (bus3.illegalD !== 1'b1 || bus3.flushReq !== 1'b0)
      $display("FAIL isa3_badforce got ill=%0b flush=%0b exp 1 0", bus3.illegalD, bus3.flushReq); else n_pass++;
    cyc();
    n_checks++; if (bus3.illegalD !== 1'b0 || bus3.isaD !== 2'd1)
      $display("FAIL isa3_badforce_end got ill=%0b isa=%0d exp 0 1", bus3.illegalD, bus3.isaD); else n_pass++;
  endtask

  task automatic test_random();
    logic [11:0] got, exp;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      bus2.validD      = 2'($urandom_range(0, 3));
      bus2.instrValidD = ($urandom_range(0, 9) != 0);
      bus2.stallD      = ($urandom_range(0, 4) == 0);
      bus2.forceValid  = ($urandom_range(0, 19) == 0);
      bus2.forceIsa    = 1'($urandom_range(0, 1));
      bus2.flushAck    = ($urandom_range(0, 3) == 0);
      cyc();
      got = {bus2.isaD, bus2.flushReq, bus2.stallReq, bus2.illegalD, bus2.switchCnt};
      exp = {1'(m_isa), m_switching, (m_switching | m_settle), m_illegal, 8'(m_switches)};
      n_checks++;
      if (got !== exp) $display("FAIL random_cyc%0d got %h exp %h", i, got, exp);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_hysteresis();
    test_glitch();
    test_illegal_stall();
    test_force();
    test_reset_mid_switch();
    test_three_isa();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
